// File: rtl/td4_pkg.sv
// Shared types and constants for the TD4 run controller.
package td4_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } run_state_t;

    // speed input encoding: divide the base period by 1, 4, 16 or 64
    localparam logic [1:0] SPEED_X1  = 2'd0;
    localparam logic [1:0] SPEED_X4  = 2'd1;
    localparam logic [1:0] SPEED_X16 = 2'd2;
    localparam logic [1:0] SPEED_X64 = 2'd3;

endpackage

// File: rtl/td4_button_debouncer.sv
// Front-panel button conditioning: 2-FF synchronizer, level debounce and
// a one-cycle press event on the debounced released->pressed transition.
module td4_button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int COUNTER_WIDTH   = 32
) (
    input  logic clock,
    input  logic n_reset,
    input  logic i_button_n,
    output logic o_press
);
    localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);

    logic                     r_sync1;
    logic                     r_sync2;
    logic                     r_level;
    logic                     r_level_d;
    logic [COUNTER_WIDTH-1:0] r_cnt;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_button_n;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // any cycle where the synced level agrees with the debounced one restarts the count
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt >= CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign o_press = r_level_d & ~r_level;

endmodule

// File: rtl/td4_run_controller.sv
// TD4 execution controller: turns run/step buttons into CPU clock-enable strobes.
// Optional breakpoint halt is compiled in when TD4_BREAKPOINT_EN is defined.
module td4_run_controller
    import td4_pkg::*;
#(
    parameter int RATIO           = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int COUNTER_WIDTH   = 32
) (
    input  logic       clock,
    input  logic       n_reset,
    input  logic       n_run_button,
    input  logic       n_step_button,
    input  logic [1:0] speed,
`ifdef TD4_BREAKPOINT_EN
    input  logic [3:0] pc,
    input  logic [3:0] break_addr,
    input  logic       break_enable,
    output logic       break_hit,
`endif
    output logic       cpu_enable,
    output logic       running,
    output logic [7:0] pulse_count
);
    localparam logic [COUNTER_WIDTH-1:0] RATIO_W = COUNTER_WIDTH'(RATIO);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    run_state_t               r_state;
    run_state_t               w_state_next;
    logic [COUNTER_WIDTH-1:0] r_rate_cnt;
    logic [COUNTER_WIDTH-1:0] w_rate_cnt_next;
    logic [COUNTER_WIDTH-1:0] w_period;
    logic [COUNTER_WIDTH-1:0] w_period_m1;
    logic                     w_run_ev;
    logic                     w_step_ev;
    logic                     w_tc;
    logic                     w_break;
    logic                     w_pulse_next;
    logic                     r_cpu_enable;
    logic [7:0]               r_pulse_count;

    td4_button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .COUNTER_WIDTH  (COUNTER_WIDTH)
    ) u_run_db (
        .clock     (clock),
        .n_reset   (n_reset),
        .i_button_n(n_run_button),
        .o_press   (w_run_ev)
    );

    td4_button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .COUNTER_WIDTH  (COUNTER_WIDTH)
    ) u_step_db (
        .clock     (clock),
        .n_reset   (n_reset),
        .i_button_n(n_step_button),
        .o_press   (w_step_ev)
    );

    always_comb begin
        case (speed)
            SPEED_X1:  w_period = RATIO_W;
            SPEED_X4:  w_period = RATIO_W >> 2;
            SPEED_X16: w_period = RATIO_W >> 4;
            default:   w_period = RATIO_W >> 6;
        endcase
    end

    // a period that shifts down to zero is clamped to one pulse per cycle
    assign w_period_m1 = (w_period == '0) ? '0 : (w_period - CNT_ONE);
    assign w_tc        = (r_rate_cnt >= w_period_m1);

`ifdef TD4_BREAKPOINT_EN
    logic r_break_hit;

    assign w_break = break_enable && (pc == break_addr);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_break_hit <= 1'b0;
        end else if ((r_state == HALT) && w_run_ev) begin
            r_break_hit <= 1'b0;
        end else if ((r_state == RUN) && !w_run_ev && w_tc && w_break) begin
            r_break_hit <= 1'b1;
        end
    end

    assign break_hit = r_break_hit;
`else
    assign w_break = 1'b0;
`endif

    // States: HALT waits for a button | RUN divided-rate strobes | STEP one strobe then HALT
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= HALT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HALT: begin
                if (w_run_ev) begin
                    w_state_next = RUN;
                end else if (w_step_ev) begin
                    w_state_next = STEP;
                end
            end
            RUN: begin
                if (w_run_ev || (w_tc && w_break)) begin
                    w_state_next = HALT;
                end
            end
            default: w_state_next = HALT;
        endcase
    end

    always_comb begin
        w_pulse_next    = 1'b0;
        w_rate_cnt_next = '0;
        case (r_state)
            HALT: begin
                w_pulse_next = !w_run_ev && w_step_ev;
            end
            RUN: begin
                if (w_run_ev) begin
                    w_rate_cnt_next = '0;
                end else if (w_tc) begin
                    w_pulse_next = !w_break;
                end else begin
                    w_rate_cnt_next = r_rate_cnt + CNT_ONE;
                end
            end
            default: begin
                w_pulse_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_rate_cnt    <= '0;
            r_cpu_enable  <= 1'b0;
            r_pulse_count <= '0;
        end else begin
            r_rate_cnt    <= w_rate_cnt_next;
            r_cpu_enable  <= w_pulse_next;
            r_pulse_count <= r_pulse_count + {7'd0, w_pulse_next};
        end
    end

    assign cpu_enable  = r_cpu_enable;
    assign running     = (r_state == RUN);
    assign pulse_count = r_pulse_count;

endmodule

// File: tb/tb_td4_run_controller.sv
// Scoreboard bench for td4_run_controller (RATIO=4, DEBOUNCE_CYCLES=4); expected
// strobe cycles are queued as buttons are driven and matched as strobes appear.
module tb_td4_run_controller;

    logic       clock         = 1'b0;
    logic       n_reset       = 1'b0;
    logic       n_run_button  = 1'b1;
    logic       n_step_button = 1'b1;
    logic [1:0] speed         = 2'd0;
    logic       cpu_enable;
    logic       running;
    logic [7:0] pulse_count;
`ifdef TD4_BREAKPOINT_EN
    logic [3:0] pc           = 4'd3;
    logic [3:0] break_addr   = 4'd3;
    logic       break_enable = 1'b0;
    logic       break_hit;
`endif

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int model_cnt = 0;
    int exp_total = 0;
    int exp_q[$];

    always #5 clock = ~clock;

    td4_run_controller #(
        .RATIO          (4),
        .DEBOUNCE_CYCLES(4),
        .COUNTER_WIDTH  (32)
    ) dut (
        .clock        (clock),
        .n_reset      (n_reset),
        .n_run_button (n_run_button),
        .n_step_button(n_step_button),
        .speed        (speed),
`ifdef TD4_BREAKPOINT_EN
        .pc           (pc),
        .break_addr   (break_addr),
        .break_enable (break_enable),
        .break_hit    (break_hit),
`endif
        .cpu_enable   (cpu_enable),
        .running      (running),
        .pulse_count  (pulse_count)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic push_train(input int first, input int gap, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(first + i * gap);
            exp_total = (exp_total + 1) % 256;
        end
    endtask

    task automatic press(input bit run, input bit step, input int hold);
        if (run)  n_run_button  = 1'b0;
        if (step) n_step_button = 1'b0;
        repeat (hold) @(negedge clock);
        n_run_button  = 1'b1;
        n_step_button = 1'b1;
        repeat (12) @(negedge clock);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Strobe monitor: every cpu_enable cycle must match the head of the queue.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (cpu_enable === 1'b1) begin
                model_cnt = (model_cnt + 1) % 256;
                if (exp_q.size() == 0) check("unexpected_pulse", cpu_enable, 0);
                else                   check("pulse_cycle", cyc, exp_q.pop_front());
                check("pulse_count_track", pulse_count, model_cnt);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        #10 n_reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_cpu_enable", cpu_enable, 0);
        check("rst_running", running, 0);
        check("rst_pulse_count", pulse_count, 0);
        repeat (100) @(negedge clock);
        check("idle_cpu_enable", cpu_enable, 0);
        check("idle_running", running, 0);
        check("idle_pulse_count", pulse_count, 0);

        // single step: strobe 7 cycles after the press, exactly once while held
        c = cyc;
        push_train(c + 7, 1, 1);
        press(0, 1, 20);
        wait_drain("step_drain");
        check("step_count", pulse_count, exp_total);
        check("step_running", running, 0);

        // short glitches never pass the debouncer
        repeat (6) begin
            n_step_button = 1'b0;
            repeat (3) @(negedge clock);
            n_step_button = 1'b1;
            repeat (3) @(negedge clock);
        end
        repeat (20) @(negedge clock);
        check("glitch_count", pulse_count, exp_total);

        // RUN at speed 0: first strobe 4 cycles after entering RUN, then every 4
        speed = 2'd0;
        c = cyc;
        push_train(c + 11, 4, 5);
        press(1, 0, 10);
        check("run_running", running, 1);
        wait_drain("run_x1");
        speed = 2'd1;
        c = cyc;
        push_train(c + 1, 1, 8);
        wait_drain("run_x4");
        speed = 2'd0;
        c = cyc;
        push_train(c + 4, 4, 2);
        wait_drain("run_back_x1");
        // stop press: one full period still completes, the partial one does not
        c = cyc;
        push_train(c + 4, 1, 1);
        press(1, 0, 10);
        wait_drain("stop_drain");
        repeat (20) @(negedge clock);
        check("stop_running", running, 0);
        check("stop_count", pulse_count, exp_total);

        // simultaneous run+step in HALT: RUN wins, no step strobe
        c = cyc;
        push_train(c + 11, 4, 5);
        press(1, 1, 10);
        check("both_running", running, 1);
        wait_drain("both_drain");
        // step while running leaves the spacing alone
        c = cyc;
        push_train(c + 4, 4, 6);
        press(0, 1, 10);
        wait_drain("step_in_run");
        c = cyc;
        push_train(c + 4, 1, 1);
        press(1, 0, 10);
        wait_drain("stop2_drain");
        check("stop2_running", running, 0);

        // reset in the middle of a strobe train at one strobe per cycle
        speed = 2'd1;
        c = cyc;
        push_train(c + 8, 1, 40);
        press(1, 0, 10);
        repeat (3) @(negedge clock);
        check("pre_reset_enable", cpu_enable, 1);
        n_reset = 1'b0;
        #1;
        check("midrst_cpu_enable", cpu_enable, 0);
        check("midrst_running", running, 0);
        check("midrst_pulse_count", pulse_count, 0);
        exp_q.delete();
        model_cnt = 0;
        exp_total = 0;
        repeat (3) @(negedge clock);
        n_reset = 1'b1;
        speed   = 2'd0;
        repeat (10) @(negedge clock);
        check("postrst_running", running, 0);

        // 256 steps from zero wrap the counter back to zero
        for (int i = 0; i < 256; i++) begin
            c = cyc;
            push_train(c + 7, 1, 1);
            press(0, 1, 8);
        end
        wait_drain("wrap_drain");
        check("wrap_count", pulse_count, 0);
        check("wrap_running", running, 0);

`ifdef TD4_BREAKPOINT_EN
        break_enable = 1'b1;
        press(1, 0, 10);
        check("bp_running", running, 0);
        check("bp_hit", break_hit, 1);
        check("bp_count", pulse_count, exp_total);
        break_enable = 1'b0;
        c = cyc;
        push_train(c + 11, 4, 5);
        press(1, 0, 10);
        check("bp_clear", break_hit, 0);
        wait_drain("bp_rerun");
        c = cyc;
        push_train(c + 4, 1, 1);
        press(1, 0, 10);
        wait_drain("bp_stop");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
